trng_cond_seq: RTL
==================

Name: trng_cond_seq

Overview:
Parametrised next-generation TRNG conditioning sequencer.
- Selects one of 2^P_SRC_WIDTH entropy sources.
- Runs 1..2^P_ROUND_WIDTH-1 chained hash-conditioning rounds, feeding each digest back as the next round's input.
- Commits the final digest to the output register.
- Guards every hash wait with a timeout and raises an error flag on expiry.
- Sits between the host command interface and the hash engine / TRNG datapath registers.

Parameters:
P_SRC_WIDTH, 2, width of entropy-source select (sources = 2^P_SRC_WIDTH)
P_ROUND_WIDTH, 4, width of round count (max 15 rounds)
P_TIMEOUT, 1023, max cycles waiting for Hash_done per round (>=1)
P_TO_WIDTH, 10, timeout counter width (must hold P_TIMEOUT)

Ports:
clk  in  1  clock, rising edge
Resetn  in  1  asynchronous active-low reset
TRNG_Go  in  1  start request, sampled only in IDLE
Op_Src  in  P_SRC_WIDTH  entropy source for round 0
Op_Rounds  in  P_ROUND_WIDTH  number of conditioning rounds; 0 treated as 1
Op_Out_Sel  in  1  output mux selection for this operation
TRNG_Done  out  1  high when idle and no operation pending
TRNG_Busy  out  1  high from accepted Go until return to IDLE
TRNG_Err  out  1  sticky timeout flag; cleared by next accepted Go
src_sel  out  P_SRC_WIDTH  entropy source mux select
chain_sel  out  1  0 = hash input from source, 1 = feedback from reg_2
out_sel  out  1  output mux select
Hash_Go  out  1  one-cycle hash start pulse
Hash_done  in  1  hash completion, sampled only in WAIT
rst_reg_1  out  1  clear output register
rst_reg_2  out  1  clear intermediate digest register
en_reg_1  out  1  load output register
en_reg_2  out  1  load intermediate digest register
round_cnt  out  P_ROUND_WIDTH  rounds completed in current operation

Behaviour:
- All outputs are registered and change only on rising clk or async reset.
- Reset values:
  - state=IDLE, TRNG_Done=1, TRNG_Busy=0, TRNG_Err=0.
  - src_sel=0, chain_sel=0, out_sel=0, Hash_Go=0, en_reg_1=0, en_reg_2=0, round_cnt=0.
  - rst_reg_1=1 and rst_reg_2=1 during reset; both drop to 0 on the first clock after release.
- States: IDLE, START, WAIT, NEXT, CAPTURE, ABORT.
- IDLE:
  - On TRNG_Go=1: latch Op_Src, Op_Rounds (0 becomes 1) and Op_Out_Sel.
  - Set Done=0, Busy=1, Err=0, round_cnt=0, chain_sel=0, src_sel=Op_Src.
  - Go to START.
- START:
  - Hash_Go=1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT:
  - Hash_done=1: en_reg_2=1 for one cycle, round_cnt+1, go to NEXT.
  - Otherwise, if timeout count reaches P_TIMEOUT: go to ABORT.
  - Otherwise: count+1.
  - If Hash_done and timeout expiry coincide, Hash_done wins.
- NEXT:
  - If round_cnt < latched rounds: chain_sel=1, go to START.
  - Otherwise: go to CAPTURE.
- CAPTURE:
  - en_reg_1=1 for one cycle; out_sel=latched Op_Out_Sel.
  - Go to IDLE with Done=1, Busy=0.
- ABORT:
  - rst_reg_1=1 and rst_reg_2=1 for one cycle; Err=1; chain_sel=0.
  - Go to IDLE with Done=1, Busy=0.
- Latency per round: 3 + k cycles, where k = cycles from Hash_Go to Hash_done.
- Total latency: Go accepted to Done high = 1 + N*(3+k) + 1 cycles.
- out_sel holds its value between operations; round_cnt holds its final value until the next accepted Go.
- TRNG_Go outside IDLE is ignored (no queuing).
- Hash_done outside WAIT is ignored.
- Op_* inputs are not sampled after acceptance.
- round_cnt saturates by construction because the maximum is 2^P_ROUND_WIDTH-1.
- Asynchronous reset mid-operation returns every output to its reset value immediately; no partial en_reg pulse.
- Reset polarity and synchronicity are fixed as above.

Decomposition:
- Package trng_pkg:
  - state encoding localparams (IDLE..ABORT, 3 bits);
  - chain_sel encodings (SEL_SRC=0, SEL_FB=1).
- Sub-module trng_timeout_cnt:
  - inputs clk, Resetn, clr, en;
  - output expired;
  - parameter P_TIMEOUT / P_TO_WIDTH.
- The FSM and the round counter remain in trng_cond_seq.

Test Plan:
- Reset, then idle: Done=1, Busy=0, Err=0, all enables 0; rst_reg_1/2 fall 1 clk after Resetn rises.
- Go with Op_Src=2, Op_Rounds=1, Op_Out_Sel=1; hash model answers with k=3 → required response:
  - one Hash_Go pulse; src_sel=2, chain_sel=0;
  - one en_reg_2 pulse, then one en_reg_1 pulse; out_sel=1;
  - Done high exactly 8 cycles after Go is accepted; round_cnt=1.
- Op_Rounds=3, k=2 → required response:
  - 3 Hash_Go pulses spaced 5 cycles apart;
  - chain_sel=0 for round 1 and 1 for rounds 2–3;
  - 3 en_reg_2 pulses, 1 en_reg_1 pulse; round_cnt=3; Err=0.
- Op_Rounds=0 → behaves exactly as Op_Rounds=1 (single Hash_Go, round_cnt=1).
- P_TIMEOUT=8, Hash_done never asserted → required response:
  - ABORT after 8 WAIT cycles; rst_reg_1/2 pulse once; no en_reg_1 pulse; Err=1, Done=1.
  - Next Go clears Err.
- Robustness stimuli:
  - Go held high throughout an operation → exactly one operation runs.
  - Spurious Hash_done in START → ignored.
  - Resetn dropped during WAIT of round 2 → outputs return to reset values immediately; a fresh operation completes normally.

Source files
------------

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state and mux-select encodings for the TRNG conditioning sequencer
`timescale 1ns/1ps
package trng_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_NEXT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ABORT   = 3'd5
    } state_t;

    // Hash input mux: entropy source or feedback from the intermediate digest.
    localparam logic SEL_SRC = 1'b0;
    localparam logic SEL_FB  = 1'b1;

endpackage

// File: rtl/trng_timeout_cnt.sv
// rtl/trng_timeout_cnt.sv - per-round hash wait timeout counter
// Ports: clk, Resetn (async active-low), clr (zero the count), en (advance the count),
//        expired (count has reached the last permitted wait cycle).
`timescale 1ns/1ps
module trng_timeout_cnt #(
    parameter int P_TIMEOUT  = 1023,
    parameter int P_TO_WIDTH = 10
) (
    input  logic clk,
    input  logic Resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The count equals the number of wait cycles already spent, so the
    // P_TIMEOUT-th wait cycle is the one that sees expired high.
    localparam logic [P_TO_WIDTH-1:0] LIMIT = P_TO_WIDTH'(P_TIMEOUT - 1);

    logic [P_TO_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + P_TO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/trng_cond_seq.sv
// rtl/trng_cond_seq.sv - TRNG conditioning sequencer: source select, chained hash rounds, commit or abort
// Ports: host side TRNG_Go/Op_Src/Op_Rounds/Op_Out_Sel in, TRNG_Done/Busy/Err out;
//        datapath side src_sel/chain_sel/out_sel, Hash_Go out, Hash_done in,
//        rst_reg_1/2 and en_reg_1/2 register controls, round_cnt progress.
// Every output is a register; values decided in a state appear during the following cycle.
`timescale 1ns/1ps
module trng_cond_seq
    import trng_pkg::*;
#(
    parameter int P_SRC_WIDTH   = 2,
    parameter int P_ROUND_WIDTH = 4,
    parameter int P_TIMEOUT     = 1023,
    parameter int P_TO_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     Resetn,
    input  logic                     TRNG_Go,
    input  logic [P_SRC_WIDTH-1:0]   Op_Src,
    input  logic [P_ROUND_WIDTH-1:0] Op_Rounds,
    input  logic                     Op_Out_Sel,
    output logic                     TRNG_Done,
    output logic                     TRNG_Busy,
    output logic                     TRNG_Err,
    output logic [P_SRC_WIDTH-1:0]   src_sel,
    output logic                     chain_sel,
    output logic                     out_sel,
    output logic                     Hash_Go,
    input  logic                     Hash_done,
    output logic                     rst_reg_1,
    output logic                     rst_reg_2,
    output logic                     en_reg_1,
    output logic                     en_reg_2,
    output logic [P_ROUND_WIDTH-1:0] round_cnt
);

    state_t                   state_q, state_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic [P_SRC_WIDTH-1:0]   src_q, src_d;
    logic                     chain_q, chain_d;
    logic                     out_sel_q, out_sel_d;
    logic                     hash_go_q, hash_go_d;
    logic                     rst1_q, rst1_d;
    logic                     rst2_q, rst2_d;
    logic                     en1_q, en1_d;
    logic                     en2_q, en2_d;
    logic [P_ROUND_WIDTH-1:0] round_q, round_d;
    logic [P_ROUND_WIDTH-1:0] rounds_lat_q, rounds_lat_d;
    logic                     osel_lat_q, osel_lat_d;

    logic to_clr, to_en, to_expired;

    trng_timeout_cnt #(
        .P_TIMEOUT  (P_TIMEOUT),
        .P_TO_WIDTH (P_TO_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .Resetn  (Resetn),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        busy_d       = busy_q;
        err_d        = err_q;
        src_d        = src_q;
        chain_d      = chain_q;
        out_sel_d    = out_sel_q;
        hash_go_d    = 1'b0;
        rst1_d       = 1'b0;
        rst2_d       = 1'b0;
        en1_d        = 1'b0;
        en2_d        = 1'b0;
        round_d      = round_q;
        rounds_lat_d = rounds_lat_q;
        osel_lat_d   = osel_lat_q;
        to_clr       = 1'b0;
        to_en        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (TRNG_Go) begin
                    // A zero round request still runs one conditioning round.
                    rounds_lat_d = (Op_Rounds == '0) ? P_ROUND_WIDTH'(1) : Op_Rounds;
                    osel_lat_d   = Op_Out_Sel;
                    src_d        = Op_Src;
                    chain_d      = SEL_SRC;
                    round_d      = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                hash_go_d = 1'b1;
                to_clr    = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over an expiry in the same cycle.
                if (Hash_done) begin
                    en2_d   = 1'b1;
                    round_d = round_q + P_ROUND_WIDTH'(1);
                    state_d = ST_NEXT;
                end else if (to_expired) begin
                    state_d = ST_ABORT;
                end else begin
                    to_en = 1'b1;
                end
            end
            ST_NEXT: begin
                if (round_q < rounds_lat_q) begin
                    chain_d = SEL_FB;
                    state_d = ST_START;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                en1_d     = 1'b1;
                out_sel_d = osel_lat_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_ABORT: begin
                // Scrub both digest registers so no partial result survives.
                rst1_d  = 1'b1;
                rst2_d  = 1'b1;
                err_d   = 1'b1;
                chain_d = SEL_SRC;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            src_q        <= '0;
            chain_q      <= SEL_SRC;
            out_sel_q    <= 1'b0;
            hash_go_q    <= 1'b0;
            rst1_q       <= 1'b1;
            rst2_q       <= 1'b1;
            en1_q        <= 1'b0;
            en2_q        <= 1'b0;
            round_q      <= '0;
            rounds_lat_q <= '0;
            osel_lat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            src_q        <= src_d;
            chain_q      <= chain_d;
            out_sel_q    <= out_sel_d;
            hash_go_q    <= hash_go_d;
            rst1_q       <= rst1_d;
            rst2_q       <= rst2_d;
            en1_q        <= en1_d;
            en2_q        <= en2_d;
            round_q      <= round_d;
            rounds_lat_q <= rounds_lat_d;
            osel_lat_q   <= osel_lat_d;
        end
    end

    assign TRNG_Done = done_q;
    assign TRNG_Busy = busy_q;
    assign TRNG_Err  = err_q;
    assign src_sel   = src_q;
    assign chain_sel = chain_q;
    assign out_sel   = out_sel_q;
    assign Hash_Go   = hash_go_q;
    assign rst_reg_1 = rst1_q;
    assign rst_reg_2 = rst2_q;
    assign en_reg_1  = en1_q;
    assign en_reg_2  = en2_q;
    assign round_cnt = round_q;

endmodule
